// File: rtl/msg_sched_ctrl_pkg.sv
// Shared constants for the SHA-256 message schedule controller: block sizes,
// sigma rotate/shift amounts and FSM state encodings.
package msg_sched_ctrl_pkg;

    localparam int SCHED_WORDS = 64;
    localparam int WIN_WORDS   = 16;

    localparam int S0_ROT_A = 7;
    localparam int S0_ROT_B = 18;
    localparam int S0_SHR_C = 3;
    localparam int S1_ROT_A = 17;
    localparam int S1_ROT_B = 19;
    localparam int S1_SHR_C = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/msg_sched_ctrl_sigma.sv
// Combinational SHA-256 small sigma: ROTR(A) ^ ROTR(B) ^ SHR(C).
module ms_sigma
    import msg_sched_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROT_A  = S0_ROT_A,
    parameter int ROT_B  = S0_ROT_B,
    parameter int SHR_C  = S0_SHR_C
) (
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = ((x >> ROT_A) | (x << (DATA_W - ROT_A)))
          ^ ((x >> ROT_B) | (x << (DATA_W - ROT_B)))
          ^ (x >> SHR_C);
    end

endmodule

// File: rtl/msg_sched_ctrl.sv
// SHA-256 message schedule generator: accepts W[0..15], expands W[16..63]
// through a 16-word sliding window, and streams all 64 words out with valid/ready.
module msg_sched_ctrl
    import msg_sched_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_idx,
    output logic              busy,
    output logic              done
);

    state_t            state, state_next;
    logic [6:0]        t;
    logic [DATA_W-1:0] win [WIN_WORDS];
    logic [DATA_W-1:0] sig0, sig1, new_word;
    logic              adv, load_fire, exp_fire;

    ms_sigma #(.DATA_W(DATA_W), .ROT_A(S0_ROT_A), .ROT_B(S0_ROT_B), .SHR_C(S0_SHR_C))
        u_sigma0 (.x(win[1]), .y(sig0));

    ms_sigma #(.DATA_W(DATA_W), .ROT_A(S1_ROT_A), .ROT_B(S1_ROT_B), .SHR_C(S1_SHR_C))
        u_sigma1 (.x(win[14]), .y(sig1));

    // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], wrapping mod 2^32
    assign new_word = sig1 + win[9] + sig0 + win[0];

    // Output register may take a new word when empty or being consumed this cycle
    assign adv = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        load_fire  = 1'b0;
        exp_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready  = adv;
                load_fire = in_valid && adv;
                if (load_fire && (t == 7'(WIN_WORDS - 1))) begin
                    state_next = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                exp_fire = adv;
                if (exp_fire && (t == 7'(SCHED_WORDS - 1))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            for (int i = 0; i < WIN_WORDS; i++) begin
                win[i] <= '0;
            end
        end else begin
            if (state == ST_IDLE && start) begin
                t <= '0;
            end
            if (load_fire || exp_fire) begin
                out_data  <= load_fire ? in_data : new_word;
                out_idx   <= t[5:0];
                out_valid <= 1'b1;
                t         <= t + 7'd1;
                for (int i = 0; i < WIN_WORDS - 1; i++) begin
                    win[i] <= win[i+1];
                end
                win[WIN_WORDS-1] <= load_fire ? in_data : new_word;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msg_sched_ctrl.sv
// Scoreboard bench for msg_sched_ctrl: expected schedules are queued at block
// start and a negedge monitor pops and compares every output transfer.
module tb_msg_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [31:0] in_data, out_data;
    logic [5:0]  out_idx;

    always #5 clk = ~clk;

    msg_sched_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [31:0] cur_msg[16];
    logic [31:0] gw[64];
    logic [31:0] cap[64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic push_schedule();
        exp_t e;
        for (int i = 0; i < 16; i++) gw[i] = cur_msg[i];
        for (int i = 16; i < 64; i++)
            gw[i] = ss1(gw[i-2]) + gw[i-7] + ss0(gw[i-15]) + gw[i-16];
        for (int i = 0; i < 64; i++) begin
            e.idx  = 6'(i);
            e.data = gw[i];
            exp_q.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                cap[out_idx] = out_data;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word idx=%0d data=%h required=no_word", out_idx, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_idx", {26'd0, out_idx}, {26'd0, e.idx});
                    chk("out_data", out_data, e.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) cur_msg[i] = 32'h0;
        cur_msg[0]  = 32'h61626380;
        cur_msg[15] = 32'h00000018;
    endtask

    task automatic set_alt();
        for (int i = 0; i < 16; i++) cur_msg[i] = 32'h01234567 ^ (32'(i) * 32'h11111111);
    endtask

    task automatic run_block(input bit toggle, input bit stall, input bit rst40, input bit start_exp);
        int   k, n, base, target;
        logic acc;
        base = done_cnt;
        push_schedule();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        k = 0;
        n = 0;
        while (k < 16 && n < 200) begin
            in_valid = toggle ? (n % 2 == 0) : 1'b1;
            in_data  = cur_msg[k];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            n++;
        end
        in_valid = 1'b0;
        in_data  = 32'h0;
        chk("words_accepted", 32'(k), 32'd16);
        chk("load_cycles", 32'(n), toggle ? 32'd31 : 32'd16);
        if (start_exp) begin
            start = 1'b1;
            cyc();
            start = 1'b0;
            chk("busy_start_in_expand", {31'd0, busy}, 32'd1);
        end
        if (stall || rst40) begin
            target = stall ? 20 : 40;
            n = 0;
            while (!(out_valid && out_idx == 6'(target)) && n < 200) begin
                cyc();
                n++;
            end
            chk("reach_idx", {26'd0, out_idx}, 32'(target));
        end
        if (stall) begin
            out_ready = 1'b0;
            repeat (5) begin
                cyc();
                chk("stall_idx", {26'd0, out_idx}, 32'd20);
                chk("stall_data", out_data, gw[20]);
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
        end
        if (rst40) begin
            rst   = 1'b1;
            start = 1'b1;
            cyc();
            rst   = 1'b0;
            start = 1'b0;
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_out_idx", {26'd0, out_idx}, 32'd0);
            chk("rst_out_data", out_data, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            exp_q.delete();
            cyc();
            chk("no_done_after_rst", 32'(done_cnt), 32'(base));
            chk("idle_after_rst", {31'd0, busy}, 32'd0);
        end else begin
            n = 0;
            while (done_cnt == base && n < 300) begin
                cyc();
                n++;
            end
            chk("done_pulses", 32'(done_cnt), 32'(base + 1));
            chk("queue_empty", 32'(exp_q.size()), 32'd0);
            chk("busy_after_done", {31'd0, busy}, 32'd0);
            chk("done_low_after", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        repeat (3) cyc();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_out_idx", {26'd0, out_idx}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        rst = 1'b0;
        cyc();

        // in_valid while idle must be ignored
        in_valid = 1'b1;
        in_data  = 32'hdeadbeef;
        repeat (3) begin
            cyc();
            chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
            chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end
        in_valid = 1'b0;
        in_data  = 32'h0;

        set_abc();
        run_block(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abc_W16", cap[16], 32'h61626380);
        chk("abc_W17", cap[17], 32'h000F0000);
        chk("abc_W0", cap[0], 32'h61626380);
        chk("abc_W15", cap[15], 32'h00000018);

        run_block(1'b0, 1'b1, 1'b0, 1'b0);
        run_block(1'b1, 1'b0, 1'b0, 1'b0);
        run_block(1'b0, 1'b0, 1'b1, 1'b0);
        run_block(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rerun_W17", cap[17], 32'h000F0000);
        run_block(1'b0, 1'b0, 1'b0, 1'b1);

        base = done_cnt;
        set_alt();
        run_block(1'b0, 1'b0, 1'b0, 1'b0);
        set_abc();
        run_block(1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_done_total", 32'(done_cnt), 32'(base + 2));

        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_sched_ctrl.md
MSG_SCHED_CTRL -- requirements
Module: msg_sched_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, begin one 64-word SHA-256 message schedule.
REQ-005 SHALL have port in_valid, input, 1, message word W[t] (t<16) offered.
REQ-006 SHALL have port in_ready, output, 1, message word accepted when in_valid&&in_ready.
REQ-007 SHALL have port in_data, input, DATA_W, message word, big-endian as per FIPS 180-4.
REQ-008 SHALL have port out_valid, output, 1, out_data/out_idx hold W[out_idx].
REQ-009 SHALL have port out_ready, input, 1, consumer takes word when out_valid&&out_ready.
REQ-010 SHALL have port out_data, output, DATA_W, schedule word W[t].
REQ-011 SHALL have port out_idx, output, 6, index t of out_data, 0..63.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after W[63] is consumed.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, EXPAND, DRAIN.
REQ-015 SHALL keep a 16-word window w[0] (W[t-16], oldest) .. w[15] (W[t-1], newest) and a 7-bit issue counter t.
REQ-016 IDLE: start=1 -> LOAD, t<=0; in_ready=0; start in any other state SHALL be ignored.
REQ-017 Define adv = !out_valid || out_ready; the output register SHALL load only when adv=1.
REQ-018 LOAD: in_ready = adv; on accept, out_data<=in_data, out_idx<=t, out_valid<=1, window shifts left with in_data into w[15], t<=t+1.
REQ-019 LOAD -> EXPAND in the cycle that t advances 15->16.
REQ-020 EXPAND: new = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], mod 2^32; when adv=1, out_data<=new, out_idx<=t, out_valid<=1, window shifts in new, t<=t+1.
REQ-021 sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-022 EXPAND -> DRAIN when W[63] is issued; DRAIN: on out_ready with out_valid, out_valid<=0, done=1 that cycle, -> IDLE.
REQ-023 Latency: out_valid SHALL assert the cycle after an input accept or expand issue; sustained throughput 1 word/cycle with out_ready=1.
REQ-024 With out_ready=0 and out_valid=1, out_data/out_idx SHALL stay stable and in_ready SHALL be 0.
REQ-025 in_valid with in_ready=0 SHALL have no effect; in_valid outside LOAD SHALL be ignored.
REQ-026 Output transfer and new issue in the same cycle SHALL both take effect (no bubble).

Reset
REQ-027 rst=1 SHALL, on the next edge, force IDLE, t=0, window=0, out_valid=0, out_data=0, out_idx=0, done=0, busy=0, in_ready=0.
REQ-028 rst mid-LOAD/EXPAND/DRAIN SHALL abandon the block with no done pulse; rst SHALL take priority over start.

Structure
REQ-029 A shared package/header SHALL hold constants SCHED_WORDS=64, WIN_WORDS=16, the six sigma rotate/shift amounts and the FSM state encodings.
REQ-030 One sub-module, ms_sigma (combinational, parameters ROT_A, ROT_B, SHR_C), SHALL be instantiated twice for sigma0/sigma1.
REQ-031 Adders SHALL be purely combinational feeding the output register; no other pipeline stage.

Verification
REQ-032 "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018, out_ready=1 -> W16=0x61626380, W17=0x000F0000, 64 words with out_idx 0..63 in order, done pulses once.
REQ-033 Same block, out_ready=0 for 5 cycles while out_idx=20 -> out_data/out_idx unchanged, no word lost or duplicated; sequence matches REQ-032 golden model.
REQ-034 in_valid toggling 1/0 each cycle during LOAD -> exactly 16 words accepted, out_idx 0..15 match inputs in order.
REQ-035 rst pulse with out_idx=40 -> next cycle out_valid=0, busy=0, no done; new start + "abc" block reproduces REQ-032.
REQ-036 start asserted during EXPAND and in_valid asserted in IDLE -> no state change, no word accepted.
REQ-037 Two back-to-back blocks (start the cycle after done) -> both schedules match the golden model, exactly two done pulses.
